ro_trace_capture: RTL

- Downstream consumer of the ring-oscillator sampling top.
- Gates the top's `go` input and, after an external trigger, captures DEPTH consecutive add-tree results into an on-chip trace buffer.
- Then streams the captured trace out over a valid/ready interface toward the host readout path.
- Supports SPA trace acquisition aligned to a victim-operation trigger.

---
 rtl/ro_trace_capture.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ro_trace_capture.sv
// Trace capture for the ring-oscillator sampling top: gates `go`, records DEPTH
// add-tree results after a trigger, then streams them out over valid/ready.
module ro_trace_capture #(
  parameter int N          = 8,
  parameter int WIDTH      = 16,
  parameter int DATA_WIDTH = WIDTH + $clog2(N),
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  ro_go,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sample_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_q;
  logic                    q_vld;
  logic                    q_last;
  logic [ADDR_WIDTH:0]     rd_ptr;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic                    wr_en;
  logic                    out_fire;
  logic                    load_out;
  logic                    q_take;
  logic                    rd_issue;

  assign dbg_state = state;
  assign wr_ptr    = sample_count[ADDR_WIDTH-1:0];

  // Stream handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, the
  // beat (out_data, out_last) is held unchanged and out_valid stays high.
  assign out_fire = out_valid && out_ready;

  assign wr_en = sample_valid && !abort && (sample_count != DEPTH_CNT) &&
                 ((state == S_CAPTURE) || ((state == S_ARMED) && trigger));

  // mem_q acts as the prefetch stage behind the output register; a new read is
  // issued only when that stage is empty or being drained this cycle.
  assign load_out = (state == S_READOUT) && (!out_valid || out_fire);
  assign q_take   = load_out && q_vld;
  assign rd_issue = (state == S_READOUT) && !abort && (rd_ptr != DEPTH_CNT) &&
                    (!q_vld || q_take);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
    if (rd_issue) mem_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ro_go        <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      rd_ptr       <= '0;
      q_vld        <= 1'b0;
      q_last       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        ro_go     <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        q_vld     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              state        <= S_ARMED;
              ro_go        <= 1'b1;
              busy         <= 1'b1;
              sample_count <= '0;
            end
          end
          S_ARMED: begin
            if (trigger) begin
              state <= S_CAPTURE;
              if (wr_en) sample_count <= sample_count + 1'b1;
            end
          end
          S_CAPTURE: begin
            if (wr_en) begin
              sample_count <= sample_count + 1'b1;
              if (sample_count == LAST_IDX) begin
                state  <= S_READOUT;
                ro_go  <= 1'b0;
                rd_ptr <= '0;
                q_vld  <= 1'b0;
              end
            end
          end
          S_READOUT: begin
            if (rd_issue) begin
              rd_ptr <= rd_ptr + 1'b1;
              q_last <= (rd_ptr == LAST_IDX);
              q_vld  <= 1'b1;
            end else if (q_take) begin
              q_vld <= 1'b0;
            end
            if (load_out) begin
              out_valid <= q_vld;
              out_last  <= q_vld && q_last;
              if (q_vld) out_data <= mem_q;
            end
            if (out_fire && out_last) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
